// File: rtl/byte_packer_if.sv
// byte_packer_if: byte input, packed-word output handshake and overflow status of byte_packer.
interface byte_packer_if #(
    parameter int WIDTH      = 8,
    parameter int NUM_BYTES  = 4,
    parameter int FIFO_DEPTH = 2
);
    logic                            in_valid;
    logic [WIDTH-1:0]                in_data;
    logic                            sync;
    logic                            out_valid;
    logic [WIDTH*NUM_BYTES-1:0]      out_data;
    logic                            out_ready;
    logic [$clog2(FIFO_DEPTH+1)-1:0] fill;
    logic                            ovf;
    logic                            ovf_clr;

    modport master (
        output in_valid, in_data, sync, out_ready, ovf_clr,
        input  out_valid, out_data, fill, ovf
    );

    modport slave (
        input  in_valid, in_data, sync, out_ready, ovf_clr,
        output out_valid, out_data, fill, ovf
    );
endinterface

// File: rtl/byte_packer.sv
// byte_packer: packs NUM_BYTES bytes LSB-first into words and queues them in a small output FIFO.
module byte_packer #(
    parameter int WIDTH      = 8,
    parameter int NUM_BYTES  = 4,
    parameter int FIFO_DEPTH = 2
) (
    input logic           clk,
    input logic           rst,
    byte_packer_if.slave  bus
);
    localparam int W  = WIDTH * NUM_BYTES;
    localparam int CW = $clog2(NUM_BYTES);
    localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam int FW = $clog2(FIFO_DEPTH + 1);

    logic [CW-1:0] cnt, cnt_n;
    logic [W-1:0]  part, part_n;
    logic [W-1:0]  mem [FIFO_DEPTH];
    logic [W-1:0]  mem_n [FIFO_DEPTH];
    logic [PW-1:0] wr, wr_n, rd, rd_n;
    logic [FW-1:0] fill, fill_n;
    logic          ovf, ovf_n, valid;
    logic [W-1:0]  data;
    logic          last, pop, push;

    assign last = bus.in_valid && !bus.sync && cnt == CW'(NUM_BYTES - 1);
    assign pop  = valid && bus.out_ready;
    assign push = last && (fill < FW'(FIFO_DEPTH) || pop);

    always_comb begin
        cnt_n  = cnt;
        part_n = part;
        mem_n  = mem;
        wr_n   = wr;
        rd_n   = rd;
        ovf_n  = ovf && !bus.ovf_clr;
        if (bus.sync) begin
            cnt_n  = bus.in_valid ? CW'(1) : '0;
            part_n = bus.in_valid ? W'(bus.in_data) : '0;
        end else if (last) begin
            cnt_n  = '0;
            part_n = '0;
        end else if (bus.in_valid) begin
            part_n[cnt*WIDTH +: WIDTH] = bus.in_data;
            cnt_n = cnt + CW'(1);
        end
        if (push) begin
            mem_n[wr] = {bus.in_data, part[W-WIDTH-1:0]};
            wr_n = wr == PW'(FIFO_DEPTH - 1) ? '0 : wr + PW'(1);
        end
        // a completed word that finds no room is dropped; the set overrides a same-edge clear
        if (last && !push)
            ovf_n = 1'b1;
        if (pop)
            rd_n = rd == PW'(FIFO_DEPTH - 1) ? '0 : rd + PW'(1);
        fill_n = fill + FW'(push) - FW'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            part  <= '0;
            mem   <= '{default: '0};
            wr    <= '0;
            rd    <= '0;
            fill  <= '0;
            ovf   <= 1'b0;
            valid <= 1'b0;
            data  <= '0;
        end else begin
            cnt   <= cnt_n;
            part  <= part_n;
            mem   <= mem_n;
            wr    <= wr_n;
            rd    <= rd_n;
            fill  <= fill_n;
            ovf   <= ovf_n;
            valid <= fill_n != '0;
            data  <= mem_n[rd_n];
        end
    end

    assign bus.out_valid = valid;
    assign bus.out_data  = data;
    assign bus.fill      = fill;
    assign bus.ovf       = ovf;
endmodule
